lsu_thread: RTL

- Per-thread load/store unit. Sits directly downstream of the per-thread register file: consumes its rs/rt outputs and produces lsu_out, which the register file writes back in UPDATE when the MEMORY mux source is selected.
- Performs one memory read or write per instruction through a valid/ready handshake to the core's memory controller.
- Reports progress on lsu_state so the core scheduler can leave WAIT only when all active threads reach DONE.

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/lsu_thread_if.sv | 34 +++
 rtl/lsu_thread.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core slice: core phase, LSU progress and
// register-file write-back mux selects.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_NONE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // Register-file write-back source select
  localparam logic [1:0] REG_IN_ARITHMETIC = 2'b00;
  localparam logic [1:0] REG_IN_MEMORY     = 2'b01;
  localparam logic [1:0] REG_IN_CONSTANT   = 2'b10;

endpackage

// File: rtl/lsu_thread_if.sv
// Memory-controller handshake for one LSU thread: a read channel and a write
// channel, each a valid/ready pair where ready is a one-cycle completion pulse.
interface lsu_thread_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  // LSU side
  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  // Memory-controller side
  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_thread.sv
// Per-thread load/store unit. One memory read or write per instruction,
// issued during the core REQUEST phase and retired back to IDLE on UPDATE.
// Optional watchdog: define LSU_TIMEOUT_EN to abort a WAITING request after
// TIMEOUT_CYCLES cycles without ready and raise the sticky lsu_error flag.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | no instruction in flight; waits for REQUEST with a mem op
// REQUESTING | one cycle while the register file latches rs/rt
// WAITING    | valid held high until the matching ready pulse
// DONE       | access retired; waits for UPDATE to return to IDLE
module lsu_thread
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 thread_active,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_thread_if.master         mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_e           state_q, state_d;
  logic                 op_read_q, op_read_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 done_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and next-output computation; everything holds while enable is low
  always_comb begin
    state_d    = state_q;
    op_read_d  = op_read_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    // Only the ready of the direction actually requested completes the access
    done_hit = op_read_q ? mem.mem_read_ready : mem.mem_write_ready;

    if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST && thread_active &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            state_d   = LSU_REQUESTING;
            // Read wins when both enables are set
            op_read_d = decoded_mem_read_enable;
          end
        end
        LSU_REQUESTING: begin
          state_d = LSU_WAITING;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (op_read_q) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = rs[ADDR_BITS-1:0];
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rs[ADDR_BITS-1:0];
            wr_data_d  = rt;
          end
        end
        LSU_WAITING: begin
          if (done_hit) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            state_d    = LSU_DONE;
            if (op_read_q) out_d = mem.mem_read_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            state_d    = LSU_DONE;
            err_d      = 1'b1;
            if (op_read_q) out_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  // State and output registers; reset withdraws any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      op_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign lsu_error = err_q;
`else
  assign lsu_error = 1'b0;
`endif

  assign lsu_state             = state_q;
  assign lsu_out               = out_q;
  assign mem.mem_read_valid    = rd_valid_q;
  assign mem.mem_read_address  = rd_addr_q;
  assign mem.mem_write_valid   = wr_valid_q;
  assign mem.mem_write_address = wr_addr_q;
  assign mem.mem_write_data    = wr_data_q;

endmodule
